// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin request arbiter.
package arb_pkg;
   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority find-first: returns the first set request bit at or above
// ptr, wrapping from the top index back to 0.
module rr_pick
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [IDX_W-1:0] cand;
   logic             hit;

   always_comb begin
      idx  = '0;
      cand = '0;
      hit  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // IDX_W-bit add wraps the search index past the top requester
         cand = ptr + IDX_W'(i);
         if (!hit && req[cand]) begin
            idx = cand;
            hit = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/req_arbiter8.sv
// 8-way round-robin arbiter with registered grant index/valid.
// Optional forced release after TIMEOUT_CYCLES grant cycles when ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no grant; arbitrate on req using ptr as the highest-priority index
// GRANT | gnt_idx owned until done (or timeout), req changes ignored
module req_arbiter8
   import arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_vld,
   output logic               timeout
);

   arb_state_t       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;

   rr_pick u_pick (
      .req (req),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         gnt_idx <= '0;
         gnt_vld <= 1'b0;
         timeout <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  gnt_idx <= pick_idx;
                  gnt_vld <= 1'b1;
                  tmo_cnt <= '0;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               // done wins over a coincident terminal count, so no pulse then
               if (done || (tmo_cnt == TMO_LAST)) begin
                  gnt_vld <= 1'b0;
                  ptr     <= gnt_idx + IDX_W'(1);
                  timeout <= ~done;
                  state   <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign timeout = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         gnt_idx <= '0;
         gnt_vld <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  gnt_idx <= pick_idx;
                  gnt_vld <= 1'b1;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               if (done) begin
                  gnt_vld <= 1'b0;
                  ptr     <= gnt_idx + IDX_W'(1);
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_req_arbiter8.sv
// Scoreboard bench for req_arbiter8: expected grant indices are queued by the
// stimulus and popped by a monitor on every new grant. ARB_TIMEOUT_EN selects the timeout checks.
module tb_req_arbiter8;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   logic prev_vld = 1'b0;

   req_arbiter8 #(.TIMEOUT_CYCLES(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // monitor: every rising gnt_vld must match the next queued grant index
   always @(negedge clk) begin
      if (gnt_vld && !prev_vld) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected: got idx %0d, expected no grant", gnt_idx);
         end else begin
            automatic int e = exp_q.pop_front();
            if (int'(gnt_idx) != e) begin
               errors++;
               $display("FAIL grant_idx: got %0d, expected %0d", gnt_idx, e);
            end
         end
      end
      prev_vld = gnt_vld;
   end

   initial begin
      int n;
      logic bad;
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("reset_vld", gnt_vld, 0);
      chk("reset_idx", gnt_idx, 0);
      chk("reset_timeout", timeout, 0);

      // single requester, one-cycle latency, held without done
      exp_q.push_back(0);
      req = 8'h01;
      step();
      chk("lat_vld", gnt_vld, 1);
      req = 8'h00;
      step(); step();
      chk("hold_vld", gnt_vld, 1);
      chk("hold_idx", gnt_idx, 0);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("release_vld", gnt_vld, 0);
      step();
      chk("idle_no_req", gnt_vld, 0);

      // full rotation from reset: 0..7,0 with one idle cycle between grants
      do_reset();
      for (int k = 0; k < 9; k++) exp_q.push_back(k % 8);
      req = 8'hFF;
      step();
      for (int k = 0; k < 9; k++) begin
         step();
         done = 1'b1;
         if (k == 8) req = 8'h00;
         step();
         done = 1'b0;
         chk("rot_idle", gnt_vld, 0);
         step();
         chk("rot_regrant", gnt_vld, (k < 8) ? 1 : 0);
      end

      // grant 5 -> ptr 6; req 0x21 with coincident done wraps to 0, then 5
      exp_q.push_back(5);
      exp_q.push_back(0);
      exp_q.push_back(5);
      req = 8'h20;
      step();
      step();
      done = 1'b1;
      req  = 8'h21;
      step();
      done = 1'b0;
      chk("wrap_idle", gnt_vld, 0);
      step();
      chk("wrap_idx0", gnt_idx, 0);
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      chk("wrap_idx5", gnt_idx, 5);
      done = 1'b1;
      req  = 8'h00;
      step();
      done = 1'b0;

      // grantee 3 drops and other requests change; grant must not move
      exp_q.push_back(3);
      req = 8'h08;
      step();
      req = 8'h00;
      step(); step();
      chk("drop_vld", gnt_vld, 1);
      chk("drop_idx", gnt_idx, 3);
      req = 8'hF7;
      step();
      chk("chg_idx", gnt_idx, 3);
      done = 1'b1;
      req  = 8'h00;
      step();
      done = 1'b0;

      // done while idle is ignored; ptr now 4 so 0x11 picks 4
      done = 1'b1;
      step();
      done = 1'b0;
      chk("idle_done_vld", gnt_vld, 0);
      exp_q.push_back(4);
      req = 8'h11;
      step();
      chk("ptr4_idx", gnt_idx, 4);

      // reset mid-grant with done and req asserted
      done = 1'b1;
      rst  = 1'b1;
      req  = 8'hFF;
      step();
      rst  = 1'b0;
      done = 1'b0;
      req  = 8'h00;
      chk("rstg_vld", gnt_vld, 0);
      chk("rstg_idx", gnt_idx, 0);
      chk("rstg_timeout", timeout, 0);
      exp_q.push_back(7);
      req = 8'h80;
      step();
      chk("rstg_next_idx", gnt_idx, 7);
      req  = 8'h00;
      done = 1'b1;
      step();
      done = 1'b0;

      // first arbitration after reset favours requester 0
      do_reset();
      exp_q.push_back(0);
      req = 8'h81;
      step();
      req = 8'h00;
      chk("favour0_vld", gnt_vld, 1);

`ifdef ARB_TIMEOUT_EN
      // ongoing grant of 0: count remaining grant cycles (it started at the previous edge)
      n = 1;
      step();
      while (gnt_vld && n < 20) begin
         n++;
         step();
      end
      chk("tmo_grant_cycles", n, 4);
      chk("tmo_pulse", timeout, 1);
      step();
      chk("tmo_pulse_end", timeout, 0);

      exp_q.push_back(2);
      req = 8'h04;
      step();
      req = 8'h00;
      step(); step(); step();
      chk("tmo_last_vld", gnt_vld, 1);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("tmo_done_vld", gnt_vld, 0);
      chk("tmo_done_pulse", timeout, 0);
`else
      bad = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (timeout !== 1'b0 || gnt_vld !== 1'b1) bad = 1'b1;
      end
      chk("no_tmo_held", int'(bad), 0);
      chk("no_tmo_idx", gnt_idx, 0);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("no_tmo_release", gnt_vld, 0);
`endif

      step(); step();
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
